ahbl_arb2: RTL
==============

# ahbl_arb2

Two-master AHB-Lite arbiter that lets the DMA controller's master port share one AHB-Lite bus with a CPU master. Each input port has an address holding register, so a losing master is stalled via its own HREADY and never loses its address phase. The single output port drives the system bus/decoder. All bursts are decomposed into single NONSEQ transfers.

## Interface
- PRIORITY, 1, arbitration policy: 0 = fixed (M0 always wins), 1 = round-robin
- HCLK  in  1  clock
- HRESETn  in  1  reset, asynchronous, active-low
- S0_HADDR / S1_HADDR  in  32  address from master 0 (CPU) / master 1 (DMAC)
- S0_HTRANS / S1_HTRANS  in  2  transfer type; only bit1 is used (NONSEQ/SEQ = request, IDLE/BUSY = none)
- S0_HWRITE / S1_HWRITE  in  1  write flag
- S0_HSIZE / S1_HSIZE  in  3  transfer size
- S0_HWDATA / S1_HWDATA  in  32  write data
- S0_HREADY / S1_HREADY  out  1  per-master ready (stall)
- S0_HRDATA / S1_HRDATA  out  32  read data, both = M_HRDATA
- M_HADDR, M_HWRITE, M_HSIZE  out  32/1/3  output address phase
- M_HTRANS  out  2  2'b10 when a transfer is issued, else 2'b00
- M_HWDATA  out  32  write data of the data-phase owner
- M_HREADY  in  1  bus ready
- M_HRDATA  in  32  bus read data
- GRANT  out  1  master owning the current output address phase (debug)

## Operation
- Per-port state: pend_x (holding reg valid), hold_x = {HADDR, HWRITE, HSIZE}.
- Output data-phase state: dp_valid, dp_owner. Address-lock state: lock, lock_owner. Round-robin pointer last.
- live_x = S_x_HTRANS[1] & S_x_HREADY & ~pend_x. req_x = pend_x | live_x.
- Address source for x: hold_x if pend_x, else the live S_x signals.
- Grant:
  - If lock, grant = lock_owner.
  - Else if PRIORITY=0, M0 wins whenever req_0.
  - Else on a tie the master ≠ last wins; a single requester always wins.
- M_HTRANS = 2'b10 iff any req; address/control come from the granted master.
- Accept = M_HTRANS active & M_HREADY. On accept:
  - pend_grant clears.
  - dp_valid <= 1, dp_owner <= grant, last <= grant.
- On M_HREADY with no transfer issued: dp_valid <= 0.
- Capture: a live_x that is not accepted this cycle (loser, or M_HREADY=0) loads hold_x and sets pend_x.
- Lock: set with lock_owner = grant when M_HTRANS active & ~M_HREADY; cleared when M_HREADY=1. This keeps the output address stable across wait states.
- S_x_HREADY = ~pend_x & (~(dp_valid & dp_owner==x) | M_HREADY).
- M_HWDATA = dp_owner ? S1_HWDATA : S0_HWDATA.
- Masters hold HWDATA while their HREADY is low, so pended writes stay valid until their output data phase.

## Timing
- Reset values: pend_0 = pend_1 = 0, dp_valid = 0, lock = 0, last = 1, GRANT = 0, M_HTRANS = 2'b00, S0_HREADY = S1_HREADY = 1.
- M_HADDR/M_HWRITE/M_HSIZE outputs are don't-care at reset.
- Uncontended live request: zero added latency (combinational pass-through). Pended request: at least 1 extra cycle.
- A master's transfer completes on the first cycle its S_x_HREADY is high after its own output data phase.
- Simultaneous completion of the old data phase and capture of a new address: legal. S_x_HREADY is 1 that cycle, then 0 until the pended transfer's output data phase completes.
- M_HREADY low: no new grant. All new live requests are pended. The locked address is held unchanged.
- BUSY/SEQ: SEQ is forwarded as NONSEQ. BUSY is treated as IDLE. M_HBURST is not generated.
- Combinational paths M_HREADY -> S_x_HREADY -> grant -> M_HTRANS are allowed. Downstream HREADYOUT must not depend combinationally on M_HTRANS.
- Reset mid-transfer: asynchronously drops all pending and data-phase state. Outputs return to reset values immediately.

## Test plan
- PRIORITY=1; M0 write 0x4000_0000 data 0x12345678, M1 idle, M_HREADY=1 -> M_HADDR=0x4000_0000 with M_HTRANS=2 in the same cycle; M_HWDATA=0x12345678 next cycle; S0_HREADY never low.
- PRIORITY=1, after reset (last=1); M0 read 0x100 and M1 write 0x200 both in cycle 0:
  - cycle 0: M0 granted, pend_1 set.
  - cycle 1: S1_HREADY=0; M_HADDR=0x200 with HWRITE=1.
  - cycle 2: M_HWDATA = M1 data; S1_HREADY=1.
- M0 data phase with M_HREADY held low 3 cycles; M1 issues 0x300 during the stall:
  - M1 is pended; S0_HREADY low 3 cycles.
  - 0x300 appears after M_HREADY rises and stays stable through any further wait states.
- PRIORITY=1; both masters issue back-to-back singles for 20 transfers -> grants alternate 0,1,0,1…; each master gets 10.
- PRIORITY=0; same stimulus as above -> M0 gets every grant while it requests; M1 is granted only on cycles M0 is IDLE.
- Assert HRESETn while pend_1 set and a data phase is in flight -> immediately M_HTRANS=0, S0_HREADY=S1_HREADY=1; no stale transfer is issued after release.

Source files
------------

// File: rtl/ahbl_arb2.sv
// Two-master AHB-Lite arbiter: per-port address holding registers let a losing
// master stall on its own HREADY; every transfer leaves as a single NONSEQ.
module ahbl_arb2 #(
  parameter logic PRIORITY = 1'b1  // 0 = fixed (M0 wins), 1 = round-robin
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] S0_HADDR,
  input  logic [1:0]  S0_HTRANS,
  input  logic        S0_HWRITE,
  input  logic [2:0]  S0_HSIZE,
  input  logic [31:0] S0_HWDATA,
  output logic        S0_HREADY,
  output logic [31:0] S0_HRDATA,
  input  logic [31:0] S1_HADDR,
  input  logic [1:0]  S1_HTRANS,
  input  logic        S1_HWRITE,
  input  logic [2:0]  S1_HSIZE,
  input  logic [31:0] S1_HWDATA,
  output logic        S1_HREADY,
  output logic [31:0] S1_HRDATA,
  output logic [31:0] M_HADDR,
  output logic [1:0]  M_HTRANS,
  output logic        M_HWRITE,
  output logic [2:0]  M_HSIZE,
  output logic [31:0] M_HWDATA,
  input  logic        M_HREADY,
  input  logic [31:0] M_HRDATA,
  output logic        GRANT
);

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
  } addr_ph_t;

  addr_ph_t r_hold0, r_hold1;
  logic     r_pend0, r_pend1;
  logic     r_dp_valid, r_dp_owner;
  logic     r_lock, r_lock_owner;
  logic     r_last;

  addr_ph_t w_live_ap0, w_live_ap1, w_ap0, w_ap1, w_m_ap;
  logic     w_hready0, w_hready1;
  logic     w_live0, w_live1;
  logic     w_req0, w_req1, w_req_any;
  logic     w_grant, w_accept;
  logic     w_unused;

  // HTRANS[0] only separates NONSEQ/SEQ and IDLE/BUSY, which are merged here.
  assign w_unused = ^{S0_HTRANS[0], S1_HTRANS[0]};

  assign w_hready0 = ~r_pend0 & (~(r_dp_valid & ~r_dp_owner) | M_HREADY);
  assign w_hready1 = ~r_pend1 & (~(r_dp_valid &  r_dp_owner) | M_HREADY);

  assign w_live0 = S0_HTRANS[1] & w_hready0 & ~r_pend0;
  assign w_live1 = S1_HTRANS[1] & w_hready1 & ~r_pend1;

  assign w_req0    = r_pend0 | w_live0;
  assign w_req1    = r_pend1 | w_live1;
  assign w_req_any = w_req0 | w_req1;

  assign w_live_ap0 = '{addr: S0_HADDR, write: S0_HWRITE, size: S0_HSIZE};
  assign w_live_ap1 = '{addr: S1_HADDR, write: S1_HWRITE, size: S1_HSIZE};
  assign w_ap0      = r_pend0 ? r_hold0 : w_live_ap0;
  assign w_ap1      = r_pend1 ? r_hold1 : w_live_ap1;

  // While locked the stalled address phase keeps its owner so the bus sees a
  // stable address across wait states.
  always_comb begin
    w_grant = 1'b0;
    if (r_lock)
      w_grant = r_lock_owner;
    else if (!PRIORITY)
      w_grant = ~w_req0 & w_req1;
    else if (w_req0 & w_req1)
      w_grant = ~r_last;
    else
      w_grant = w_req1;
  end

  assign w_m_ap   = w_grant ? w_ap1 : w_ap0;
  assign w_accept = w_req_any & M_HREADY;

  assign M_HADDR   = w_m_ap.addr;
  assign M_HWRITE  = w_m_ap.write;
  assign M_HSIZE   = w_m_ap.size;
  assign M_HTRANS  = w_req_any ? 2'b10 : 2'b00;
  assign M_HWDATA  = r_dp_owner ? S1_HWDATA : S0_HWDATA;
  assign GRANT     = w_grant;
  assign S0_HREADY = w_hready0;
  assign S1_HREADY = w_hready1;
  assign S0_HRDATA = M_HRDATA;
  assign S1_HRDATA = M_HRDATA;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_dp_valid   <= 1'b0;
      r_dp_owner   <= 1'b0;
      r_last       <= 1'b1;
      r_lock       <= 1'b0;
      r_lock_owner <= 1'b0;
    end else begin
      if (w_accept) begin
        r_dp_valid <= 1'b1;
        r_dp_owner <= w_grant;
        r_last     <= w_grant;
      end else if (M_HREADY) begin
        r_dp_valid <= 1'b0;
      end
      if (M_HREADY) begin
        r_lock <= 1'b0;
      end else if (w_req_any) begin
        r_lock       <= 1'b1;
        r_lock_owner <= w_grant;
      end
    end
  end

  // A live request that is not accepted this cycle is parked in its holding register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_pend0 <= 1'b0;
      r_hold0 <= '0;
    end else if (w_live0 && !(w_accept && !w_grant)) begin
      r_pend0 <= 1'b1;
      r_hold0 <= w_live_ap0;
    end else if (w_accept && !w_grant) begin
      r_pend0 <= 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_pend1 <= 1'b0;
      r_hold1 <= '0;
    end else if (w_live1 && !(w_accept && w_grant)) begin
      r_pend1 <= 1'b1;
      r_hold1 <= w_live_ap1;
    end else if (w_accept && w_grant) begin
      r_pend1 <= 1'b0;
    end
  end

endmodule
